audio_slow_sequencer: RTL and testbench
=======================================

Name: audio_slow_sequencer

Overview:
- Slow-playback sample sequencer placed between the SRAM sample fetch path and the interpolation divider.
- For each input sample it emits N output samples, where N is the slowdown factor (1..8).
- In interpolation mode it drives prev/current samples and N into the divider.
- It registers the returned quotient and accumulates prev + k*quotient; in hold mode it repeats prev.
- Output feeds the DAC/I2S stage through a valid/ready handshake.

Parameters:
SPEED_MAX, 8, largest legal slowdown factor; must match the divider's supported divisor range.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_start  input  1  1-cycle pulse: begin slow playback
i_stop  input  1  1-cycle pulse: abort and return to idle
i_interp  input  1  1 = linear interpolation, 0 = zero-order hold; sampled at start
i_speed  input  4  slowdown factor N; sampled at start
i_in_valid  input  1  upstream sample valid
i_in_data  input  16  upstream sample, two's complement
o_in_ready  output  1  sequencer accepts a sample this cycle
o_div_prev  output  16  to divider: previous sample
o_div_curr  output  16  to divider: current sample
o_div_divisor  output  4  to divider: latched N
i_div_quotient  input  16  from divider: approximately (curr-prev)/N, combinational
o_out_valid  output  1  output sample valid
o_out_data  output  16  output sample
i_out_ready  input  1  downstream accepts output
o_busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock/reset: single clock i_clk; i_rst is synchronous, active-high, and highest priority.
- Reset state: state=IDLE; prev, curr, acc, q, k, speed_r, interp_r all 0.
  - Outputs o_in_ready=0, o_out_valid=0, o_out_data=0, o_busy=0.
  - Outputs o_div_prev=0, o_div_curr=0, o_div_divisor=0.
- Registered state: prev, curr, acc (all 16 bit); q (16 bit); k (4 bit); speed_r (4 bit); interp_r (1 bit).
- Divider connections: o_div_prev=prev, o_div_curr=curr, o_div_divisor=speed_r.
- IDLE:
  - On i_start (and not i_stop): speed_r <= clamp(i_speed), interp_r <= i_interp, prev <= 0, curr <= 0; next state FETCH.
  - clamp: 0 -> 1; values above SPEED_MAX -> SPEED_MAX.
- FETCH:
  - o_in_ready=1.
  - On i_in_valid: prev <= curr, curr <= i_in_data, acc <= curr (old value), k <= 0; next state LOAD.
  - No other state asserts o_in_ready.
- LOAD (exactly 1 cycle):
  - q <= i_div_quotient; the divider now sees the updated prev and curr. Next state EMIT.
  - Fixed latency: input handshake to first o_out_valid is 2 cycles.
- EMIT:
  - o_out_valid=1.
  - o_out_data = acc when interp_r=1, else prev.
  - On i_out_ready:
    - acc <= acc + q, 16-bit wrap-around with no saturation.
    - If k == speed_r-1, go to FETCH; otherwise k <= k+1 and stay in EMIT.
  - Backpressure: while i_out_ready=0, o_out_data and o_out_valid hold stable.
- Output pattern: each input sample yields exactly speed_r outputs. The first output after start reflects prev=0, giving a one-sample pipeline delay.
- Speed 1: q = curr-prev, so the output stream equals the input stream delayed by one sample in both modes.
- i_stop in any non-IDLE state: next cycle IDLE.
  - Pending output is dropped; a sample offered in that same cycle is not accepted (o_in_ready forced 0 by i_stop).
  - prev, curr and acc are not cleared.
- i_start outside IDLE is ignored.
- i_start and i_stop in the same cycle: stop wins; stay in or return to IDLE.
- i_speed and i_interp changes after start are ignored until the next start.
- Reset mid-operation: returns to the reset state in the next cycle; no further handshakes complete.
- No combinational path from i_out_ready or i_in_valid to any output.

Test Plan:
- Linear ramp, 4x, interp=1; inputs 400, 0, 0:
  - Outputs 0,100,200,300, then 400,300,200,100, then 0,0,0,0.
  - First o_out_valid appears 2 cycles after the first input handshake.
- Approximate divisor, speed=3, interp=1; inputs 300, 300:
  - Outputs 0,97,194, then 300,300,300 (quotient 75+18+4=97 from the divider's shift approximation).
- Hold mode, speed=2, interp=0; inputs 5, -7, 9:
  - Outputs 0,0,5,5,-7,-7.
  - o_in_ready pulses once per two accepted outputs.
- Backpressure: hold i_out_ready=0 for 5 cycles mid-EMIT:
  - o_out_data remains stable, k does not advance, no sample is lost or duplicated.
- Speed clamps: speed=0 gives one output per input; speed=12 gives 8 outputs per input and o_div_divisor=8.
- Control corner cases:
  - Assert i_stop during EMIT at k=2: o_out_valid=0 and o_busy=0 next cycle.
  - Start and stop in the same cycle: stays IDLE.
  - i_rst during LOAD: all outputs 0 next cycle.

Source files
------------

// File: rtl/audio_slow_sequencer.sv
// rtl/audio_slow_sequencer.sv - slow-playback sample sequencer feeding an interpolation divider
module audio_slow_sequencer #(
  parameter int SPEED_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_interp,
  input  logic [3:0]  i_speed,
  input  logic        i_in_valid,
  input  logic [15:0] i_in_data,
  output logic        o_in_ready,
  output logic [15:0] o_div_prev,
  output logic [15:0] o_div_curr,
  output logic [3:0]  o_div_divisor,
  input  logic [15:0] i_div_quotient,
  output logic        o_out_valid,
  output logic [15:0] o_out_data,
  input  logic        i_out_ready,
  output logic        o_busy
);

  localparam logic [3:0] SPEED_MAX_L = 4'(SPEED_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] curr_q, curr_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] q_q, q_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  speed_q, speed_d;
  logic        interp_q, interp_d;
  logic [3:0]  speed_clamped;

  // Legal slowdown range is 1..SPEED_MAX; out-of-range requests are pinned to the nearest end.
  always_comb begin
    speed_clamped = i_speed;
    if (i_speed == 4'd0) begin
      speed_clamped = 4'd1;
    end else if (i_speed > SPEED_MAX_L) begin
      speed_clamped = SPEED_MAX_L;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      curr_q   <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      k_q      <= '0;
      speed_q  <= '0;
      interp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      k_q      <= k_d;
      speed_q  <= speed_d;
      interp_q <= interp_d;
    end
  end

  // Next-state and handshake logic; stop in any active state preempts everything else.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    curr_d     = curr_q;
    acc_d      = acc_q;
    q_d        = q_q;
    k_d        = k_q;
    speed_d    = speed_q;
    interp_d   = interp_q;
    o_in_ready = 1'b0;

    if (state_q != S_IDLE && i_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            speed_d  = speed_clamped;
            interp_d = i_interp;
            prev_d   = '0;
            curr_d   = '0;
            state_d  = S_FETCH;
          end
        end
        S_FETCH: begin
          o_in_ready = 1'b1;
          if (i_in_valid) begin
            prev_d  = curr_q;
            curr_d  = i_in_data;
            acc_d   = curr_q;
            k_d     = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          // Divider has now seen the new prev/curr pair; capture its step size.
          q_d     = i_div_quotient;
          state_d = S_EMIT;
        end
        S_EMIT: begin
          if (i_out_ready) begin
            acc_d = acc_q + q_q;
            if (k_q == speed_q - 4'd1) begin
              state_d = S_FETCH;
            end else begin
              k_d = k_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs come only from registered state, so ready/valid inputs never reach them.
  always_comb begin
    o_out_valid   = (state_q == S_EMIT);
    o_out_data    = '0;
    if (state_q == S_EMIT) begin
      o_out_data = interp_q ? acc_q : prev_q;
    end
    o_busy        = (state_q != S_IDLE);
    o_div_prev    = prev_q;
    o_div_curr    = curr_q;
    o_div_divisor = speed_q;
  end

endmodule

// File: tb/tb_audio_slow_sequencer.sv
// tb/tb_audio_slow_sequencer.sv - randomized self-checking bench for audio_slow_sequencer
module tb_audio_slow_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, interp;
  logic [3:0]  speed;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] div_prev, div_curr;
  logic [3:0]  div_divisor;
  logic [15:0] div_q;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_slow_sequencer #(.SPEED_MAX(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_interp(interp),
    .i_speed(speed), .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_div_prev(div_prev), .o_div_curr(div_curr), .o_div_divisor(div_divisor),
    .i_div_quotient(div_q), .o_out_valid(out_valid), .o_out_data(out_data),
    .i_out_ready(out_ready), .o_busy(busy)
  );

  // Divider model: exact shifts for powers of two, shift-sum approximation for 3, else truncating divide.
  function automatic logic [15:0] divf(input logic [15:0] p, input logic [15:0] c, input logic [3:0] n);
    int d, r;
    d = int'($signed(c)) - int'($signed(p));
    case (n)
      4'd0: r = 0;
      4'd1: r = d;
      4'd2: r = d >>> 1;
      4'd3: r = (d >>> 2) + (d >>> 4) + (d >>> 6);
      4'd4: r = d >>> 2;
      4'd8: r = d >>> 3;
      default: r = d / int'(n);
    endcase
    return r[15:0];
  endfunction

  assign div_q = divf(div_prev, div_curr, div_divisor);

  // Reference: each sample s yields N points on the line from the previous sample toward s.
  task automatic model(input logic [15:0] smp[$], input int sp, input bit ip, output logic [15:0] ex[$]);
    int n;
    logic [15:0] p, c, q, v;
    n = (sp == 0) ? 1 : (sp > 8) ? 8 : sp;
    p = 16'd0;
    c = 16'd0;
    ex = {};
    foreach (smp[i]) begin
      p = c;
      c = smp[i];
      q = divf(p, c, 4'(n));
      for (int j = 0; j < n; j++) begin
        v = p + 16'(j) * q;
        ex.push_back(ip ? v : p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] sp, input bit ip);
    speed = sp;
    interp = ip;
    start = 1'b1;
    tick();
    start = 1'b0;
    speed = $urandom_range(0, 15);
    interp = $urandom_range(0, 1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Feeds samples and collects accepted outputs until n_out are seen or the cycle budget runs out.
  task automatic run_stream(input logic [15:0] smp[$], input int n_out, input bit rnd_rdy,
                            output logic [15:0] outs[$], output int lat, output int n_in);
    int cyc, first_in, idx;
    cyc = 0;
    first_in = -1;
    idx = 0;
    lat = -1;
    n_in = 0;
    outs = {};
    while (outs.size() < n_out && cyc < 2000) begin
      in_valid = (idx < smp.size());
      in_data = in_valid ? smp[idx] : 16'd0;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_ready && in_valid) begin
        idx++;
        n_in++;
        if (first_in < 0) first_in = cyc;
      end
      if (out_valid) begin
        if (lat < 0 && first_in >= 0) lat = cyc - first_in;
        if (out_ready) outs.push_back(out_data);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000", {in_ready, out_valid, busy});
    end
    tests++;
    if (out_data !== 16'd0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0000", out_data);
    end
    tests++;
    if ({div_prev, div_curr, div_divisor} !== 36'd0) begin
      fails++;
      $display("FAIL reset_div: got %h/%h/%h want 0", div_prev, div_curr, div_divisor);
    end
  endtask

  task automatic test_ramp();
    logic [15:0] smp[$], outs[$], ex[$];
    int lat, n_in;
    smp = {16'd400, 16'd0, 16'd0};
    ex = {16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd300, 16'd200, 16'd100,
          16'd0, 16'd0, 16'd0, 16'd0};
    pulse_start(4'd4, 1'b1);
    run_stream(smp, 12, 1'b0, outs, lat, n_in);
    tests++;
    if (outs.size() !== 12) begin
      fails++;
      $display("FAIL ramp_count: got %0d want 12", outs.size());
    end
    foreach (outs[i]) begin
      tests++;
      if (outs[i] !== ex[i]) begin
        fails++;
        $display("FAIL ramp_out[%0d]: got %0d want %0d", i, outs[i], ex[i]);
      end
    end
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL ramp_latency: got %0d want 2", lat);
    end
    pulse_stop();
  endtask

  task automatic test_approx();
    logic [15:0] smp[$], outs[$], ex[$];
    int lat, n_in;
    smp = {16'd300, 16'd300};
    ex = {16'd0, 16'd97, 16'd194, 16'd300, 16'd300, 16'd300};
    pulse_start(4'd3, 1'b1);
    run_stream(smp, 6, 1'b0, outs, lat, n_in);
    tests++;
    if (outs.size() !== 6) begin
      fails++;
      $display("FAIL approx_count: got %0d want 6", outs.size());
    end
    foreach (outs[i]) begin
      tests++;
      if (outs[i] !== ex[i]) begin
        fails++;
        $display("FAIL approx_out[%0d]: got %0d want %0d", i, outs[i], ex[i]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_hold();
    logic [15:0] smp[$], outs[$], ex[$];
    int lat, n_in;
    smp = {16'd5, 16'hFFF9, 16'd9};
    ex = {16'd0, 16'd0, 16'd5, 16'd5, 16'hFFF9, 16'hFFF9};
    pulse_start(4'd2, 1'b0);
    run_stream(smp, 6, 1'b0, outs, lat, n_in);
    tests++;
    if (outs.size() !== 6) begin
      fails++;
      $display("FAIL hold_count: got %0d want 6", outs.size());
    end
    foreach (outs[i]) begin
      tests++;
      if (outs[i] !== ex[i]) begin
        fails++;
        $display("FAIL hold_out[%0d]: got %h want %h", i, outs[i], ex[i]);
      end
    end
    tests++;
    if (n_in !== 3) begin
      fails++;
      $display("FAIL hold_inputs: got %0d want 3", n_in);
    end
    pulse_stop();
  endtask

  task automatic test_backpressure();
    logic [15:0] smp[$], none[$], outs[$], ex[$];
    int lat, n_in;
    smp = {16'd800};
    none = {};
    ex = {16'd400, 16'd600};
    pulse_start(4'd4, 1'b1);
    run_stream(smp, 2, 1'b0, outs, lat, n_in);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'd400) begin
        fails++;
        $display("FAIL bp_stall[%0d]: got v=%b d=%0d want v=1 d=400", c, out_valid, out_data);
      end
      tick();
    end
    run_stream(none, 2, 1'b0, outs, lat, n_in);
    tests++;
    if (outs.size() !== 2 || outs[0] !== ex[0] || outs[1] !== ex[1]) begin
      fails++;
      $display("FAIL bp_resume: got %p want %p", outs, ex);
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_next_fetch: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    pulse_stop();
  endtask

  task automatic test_clamp();
    logic [15:0] smp[$], outs[$], ex[$];
    int lat, n_in;
    smp = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    ex = {16'd0, smp[0], smp[1], smp[2]};
    pulse_start(4'd0, 1'b1);
    tests++;
    if (div_divisor !== 4'd1) begin
      fails++;
      $display("FAIL clamp_low_div: got %0d want 1", div_divisor);
    end
    run_stream(smp, 4, 1'b1, outs, lat, n_in);
    tests++;
    if (outs != ex || n_in !== 4) begin
      fails++;
      $display("FAIL clamp_low_out: got %p (%0d in) want %p (4 in)", outs, n_in, ex);
    end
    pulse_stop();
    smp = {16'd1600, 16'($urandom)};
    model(smp, 12, 1'b1, ex);
    pulse_start(4'd12, 1'b1);
    tests++;
    if (div_divisor !== 4'd8) begin
      fails++;
      $display("FAIL clamp_high_div: got %0d want 8", div_divisor);
    end
    run_stream(smp, 16, 1'b0, outs, lat, n_in);
    tests++;
    if (outs != ex || n_in !== 2) begin
      fails++;
      $display("FAIL clamp_high_out: got %p (%0d in) want %p (2 in)", outs, n_in, ex);
    end
    pulse_stop();
  endtask

  task automatic test_stop_emit();
    logic [15:0] smp[$], outs[$];
    int lat, n_in;
    smp = {16'd1234};
    pulse_start(4'd4, 1'b1);
    run_stream(smp, 2, 1'b0, outs, lat, n_in);
    out_ready = 1'b1;
    pulse_stop();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stop_emit: got v=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
    end
    tests++;
    if (div_curr !== 16'd1234) begin
      fails++;
      $display("FAIL stop_keeps_curr: got %0d want 1234", div_curr);
    end
    pulse_start(4'd2, 1'b1);
    stop = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd77;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stop_fetch_ready: got %b want 0", in_ready);
    end
    tick();
    stop = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || div_curr !== 16'd0) begin
      fails++;
      $display("FAIL stop_fetch: got busy=%b curr=%0d want 0 0", busy, div_curr);
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop = 1'b1;
    speed = 4'd3;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_stop: got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reset_load();
    pulse_start(4'd4, 1'b1);
    in_valid = 1'b1;
    in_data = 16'd999;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy, out_data, div_prev, div_curr, div_divisor} !== 55'd0) begin
      fails++;
      $display("FAIL reset_load: got rdy=%b v=%b busy=%b d=%h p=%h c=%h n=%h want all 0",
               in_ready, out_valid, busy, out_data, div_prev, div_curr, div_divisor);
    end
  endtask

  task automatic test_random();
    logic [15:0] smp[$], outs[$], ex[$];
    int lat, n_in, sp, nsmp;
    bit ip;
    for (int it = 0; it < 20; it++) begin
      sp = $urandom_range(0, 15);
      ip = 1'($urandom_range(0, 1));
      nsmp = $urandom_range(1, 5);
      smp = {};
      for (int s = 0; s < nsmp; s++) smp.push_back(16'($urandom));
      model(smp, sp, ip, ex);
      pulse_start(4'(sp), ip);
      run_stream(smp, ex.size(), 1'b1, outs, lat, n_in);
      tests++;
      if (outs != ex) begin
        fails++;
        $display("FAIL random[%0d] sp=%0d ip=%0d: got %p want %p", it, sp, ip, outs, ex);
      end
      pulse_stop();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    interp = 1'b0;
    speed = 4'd0;
    in_valid = 1'b0;
    in_data = 16'd0;
    out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_approx();
    test_hold();
    test_backpressure();
    test_clamp();
    test_stop_emit();
    test_start_stop();
    test_reset_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
